// File: rtl/float24_pkg.sv
// float24_pkg
// Shared definitions for the float24 codec path: the float24 field layout
// (1 sign, 7 exponent with bias 63, 16 fraction), the Q1.23 saturation limits
// and the input-side FSM state encoding.
package float24_pkg;

  localparam int FLT_W    = 24;
  localparam int EXP_W    = 7;
  localparam int FRAC_W   = 16;
  localparam int EXP_BIAS = 63;

  // Exponent at which the 17-bit mantissa {1,frac} lines up with Q1.23
  // without shifting: the bias minus the 7 extra fixed-point bits.
  localparam int UNIT_EXP = EXP_BIAS - (FLT_W - 1 - FRAC_W);

  localparam logic [FLT_W-1:0] FIX_MAX = 24'h7FFFFF;
  localparam logic [FLT_W-1:0] FIX_MIN = 24'h800000;

  typedef enum logic [1:0] {
    ST_EMPTY  = 2'd0,
    ST_CONV_L = 2'd1,
    ST_CONV_R = 2'd2,
    ST_FULL   = 2'd3
  } in_state_e;

endpackage

// File: rtl/float24_to_fix24.sv
// float24_to_fix24
// Purely combinational float24 -> Q1.23 converter with saturation.
// Zero exponent flushes to zero (denormals included); |v| >= 1 saturates.
// Ports:
//   flt_i  in  24  float24 sample
//   fix_o  out 24  signed Q1.23 result
module float24_to_fix24
  import float24_pkg::*;
(
  input  logic [FLT_W-1:0] flt_i,
  output logic [FLT_W-1:0] fix_o
);

  logic             sign;
  logic [EXP_W-1:0] expo;
  logic [FLT_W-1:0] mant;
  logic [FLT_W-1:0] mag;

  assign sign = flt_i[FLT_W-1];
  assign expo = flt_i[FLT_W-2 -: EXP_W];
  assign mant = FLT_W'({1'b1, flt_i[FRAC_W-1:0]});

  // Right shifts of 17 or more clear the 17-bit mantissa entirely, which is
  // exactly the required truncation, so no separate range check is needed.
  always_comb begin
    mag   = '0;
    fix_o = '0;
    if (expo == '0) begin
      fix_o = '0;
    end else if (expo >= EXP_W'(EXP_BIAS)) begin
      fix_o = sign ? FIX_MIN : FIX_MAX;
    end else begin
      if (expo >= EXP_W'(UNIT_EXP)) begin
        mag = mant << (expo - EXP_W'(UNIT_EXP));
      end else begin
        mag = mant >> (EXP_W'(UNIT_EXP) - expo);
      end
      fix_o = sign ? -mag : mag;
    end
  end

endmodule

// File: rtl/float24_codec_tx.sv
// float24_codec_tx
// Transmit side of the codec interface. Accepts a stereo float24 pair,
// converts both channels to Q1.23 through one shared converter, and sends
// them as an I2S frame with locally generated bit and word clocks.
// Ports:
//   clk, rst            system clock, synchronous active-high reset
//   in_left, in_right   float24 samples; in_valid/in_ready handshake
//   codec_bclk          bit clock, period 2*CLK_DIV clk
//   codec_lrclk         word clock, 0 = left slot, 1 = right slot
//   codec_sdata         serial data, MSB first, one bclk after lrclk edge
//   underrun            one-cycle pulse when a frame starts with nothing ready
module float24_codec_tx
  import float24_pkg::*;
#(
  parameter int CLK_DIV = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [FLT_W-1:0] in_left,
  input  logic [FLT_W-1:0] in_right,
  input  logic             in_valid,
  output logic             in_ready,
  output logic             codec_bclk,
  output logic             codec_lrclk,
  output logic             codec_sdata,
  output logic             underrun
);

  localparam int DIV_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

  in_state_e        state_q, state_d;
  logic [FLT_W-1:0] rawLeft_q, rawLeft_d, rawRight_q, rawRight_d;
  logic [FLT_W-1:0] holdLeft_q, holdLeft_d, holdRight_q, holdRight_d;
  logic [FLT_W-1:0] txLeft_q, txLeft_d, txRight_q, txRight_d;
  logic [DIV_W-1:0] divCnt_q, divCnt_d;
  logic [5:0]       bitCnt_q, bitCnt_d;
  logic             bclk_q, bclk_d, lrclk_q, lrclk_d, sdata_q, sdata_d;
  logic             underrun_q, underrun_d;

  logic             wrap, fall, frameStart, slotBit;
  logic [5:0]       bitCntNext;
  logic [4:0]       slotPos;
  logic [FLT_W-1:0] slotWord, convIn, convOut;

  // The single converter sees whichever raw sample the FSM is working on.
  assign convIn = (state_q == ST_CONV_R) ? rawRight_q : rawLeft_q;

  float24_to_fix24 u_conv (
    .flt_i (convIn),
    .fix_o (convOut)
  );

  assign wrap       = (divCnt_q == DIV_W'(CLK_DIV - 1));
  assign fall       = wrap && bclk_q;
  assign bitCntNext = bitCnt_q + 6'd1;
  assign frameStart = fall && (bitCntNext == 6'd0);
  assign slotPos    = bitCntNext[4:0];
  assign slotWord   = bitCntNext[5] ? txRight_q : txLeft_q;

  assign in_ready    = (state_q == ST_EMPTY) && !rst;
  assign codec_bclk  = bclk_q;
  assign codec_lrclk = lrclk_q;
  assign codec_sdata = sdata_q;
  assign underrun    = underrun_q;

  // Slot position 0 is the I2S delay bit; positions 1..24 carry the word
  // MSB first and the tail of the 32-bit slot is padded with zeros.
  always_comb begin
    slotBit = 1'b0;
    if (slotPos != 5'd0 && slotPos <= 5'd24) begin
      slotBit = slotWord[5'd24 - slotPos];
    end
  end

  // Input FSM: capture the raw pair, convert left then right, then hold the
  // result until the serializer takes it at a frame start.
  always_comb begin
    state_d     = state_q;
    rawLeft_d   = rawLeft_q;
    rawRight_d  = rawRight_q;
    holdLeft_d  = holdLeft_q;
    holdRight_d = holdRight_q;
    case (state_q)
      ST_EMPTY: begin
        if (in_valid) begin
          rawLeft_d  = in_left;
          rawRight_d = in_right;
          state_d    = ST_CONV_L;
        end
      end
      ST_CONV_L: begin
        holdLeft_d = convOut;
        state_d    = ST_CONV_R;
      end
      ST_CONV_R: begin
        holdRight_d = convOut;
        state_d     = ST_FULL;
      end
      ST_FULL: begin
        if (frameStart) state_d = ST_EMPTY;
      end
      default: state_d = ST_EMPTY;
    endcase
  end

  // Serializer: everything but the divider and bclk moves only on a bclk
  // fall. A frame start with no completed pair sends zeros and flags it.
  always_comb begin
    divCnt_d   = wrap ? '0 : divCnt_q + DIV_W'(1);
    bclk_d     = wrap ? ~bclk_q : bclk_q;
    bitCnt_d   = bitCnt_q;
    lrclk_d    = lrclk_q;
    sdata_d    = sdata_q;
    txLeft_d   = txLeft_q;
    txRight_d  = txRight_q;
    underrun_d = 1'b0;
    if (fall) begin
      bitCnt_d = bitCntNext;
      lrclk_d  = bitCntNext[5];
      sdata_d  = slotBit;
      if (frameStart) begin
        if (state_q == ST_FULL) begin
          txLeft_d  = holdLeft_q;
          txRight_d = holdRight_q;
        end else begin
          txLeft_d   = '0;
          txRight_d  = '0;
          underrun_d = 1'b1;
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= ST_EMPTY;
      rawLeft_q   <= '0;
      rawRight_q  <= '0;
      holdLeft_q  <= '0;
      holdRight_q <= '0;
      txLeft_q    <= '0;
      txRight_q   <= '0;
      divCnt_q    <= '0;
      bitCnt_q    <= '0;
      bclk_q      <= 1'b0;
      lrclk_q     <= 1'b0;
      sdata_q     <= 1'b0;
      underrun_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      rawLeft_q   <= rawLeft_d;
      rawRight_q  <= rawRight_d;
      holdLeft_q  <= holdLeft_d;
      holdRight_q <= holdRight_d;
      txLeft_q    <= txLeft_d;
      txRight_q   <= txRight_d;
      divCnt_q    <= divCnt_d;
      bitCnt_q    <= bitCnt_d;
      bclk_q      <= bclk_d;
      lrclk_q     <= lrclk_d;
      sdata_q     <= sdata_d;
      underrun_q  <= underrun_d;
    end
  end

endmodule

// File: tb/tb_float24_codec_tx.sv
// tb_float24_codec_tx
// Self-checking bench for float24_codec_tx. A frame-level reference model
// predicts clocks, ready, underrun and the decoded slot contents, and an
// I2S receiver rebuilds each frame from the serial pins.
module tb_float24_codec_tx;

  localparam int CLK_DIV   = 4;
  localparam int FRAME_CYC = 128 * CLK_DIV;

  logic        clk      = 1'b0;
  logic        rst      = 1'b1;
  logic [23:0] inLeft   = '0;
  logic [23:0] inRight  = '0;
  logic        inValid  = 1'b0;
  logic        inReady, bclk, lrclk, sdata, underrun;

  float24_codec_tx #(.CLK_DIV(CLK_DIV)) dut (
    .clk         (clk),
    .rst         (rst),
    .in_left     (inLeft),
    .in_right    (inRight),
    .in_valid    (inValid),
    .in_ready    (inReady),
    .codec_bclk  (bclk),
    .codec_lrclk (lrclk),
    .codec_sdata (sdata),
    .underrun    (underrun)
  );

  always #5 clk = ~clk;

  int vectors     = 0;
  int miscompares = 0;

  task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("[TB] FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
    end
  endtask

  // Value of the float is (1 + frac/2^16) * 2^(e-63); in units of 2^-23
  // that is m * 2^(e-56) with m = 65536 + frac, truncated toward zero.
  function automatic logic [23:0] refConv(input logic [23:0] f);
    int     e;
    longint m, mag, scale;
    e = int'(f[22:16]);
    m = 65536 + longint'(f[15:0]);
    if (e == 0) return 24'h000000;
    if (e >= 63) return f[23] ? 24'h800000 : 24'h7FFFFF;
    scale = 1;
    if (e >= 56) begin
      for (int i = 0; i < e - 56; i++) scale = scale * 2;
      mag = m * scale;
    end else begin
      for (int i = 0; i < 56 - e; i++) scale = scale * 2;
      mag = m / scale;
    end
    if (f[23]) mag = -mag;
    return mag[23:0];
  endfunction

  function automatic logic [23:0] randFloat();
    logic [23:0] f;
    f[23]    = 1'($urandom % 2);
    f[22:16] = ($urandom % 2 == 0) ? 7'($urandom_range(50, 66)) : 7'($urandom_range(0, 127));
    f[15:0]  = 16'($urandom);
    return f;
  endfunction

  // Reference model state
  int          cyc = 0;
  bit          pend = 0;
  logic [23:0] pendL, pendR;
  int          acceptEdge = 0;
  int          acceptCount = 0;
  int          sent = 0;
  bit          expUr = 0;
  logic [47:0] expFrames[$];
  logic [47:0] headFrame;

  // Receiver state
  bit          prevBclk = 0;
  bit          prevLr = 0;
  int          slotPos = -1;
  logic [23:0] shiftWord = '0;
  logic [23:0] gotLeft = '0;
  bit          haveLeft = 0;
  int          framesChecked = 0;

  // Check this cycle's outputs, decode serial data on bclk rises, then
  // advance the model to what the coming rising edge will do.
  always @(negedge clk) begin : modelBlk
    bit oldReady;
    checkOutput("in_ready", 32'(inReady), 32'(!pend && !rst));
    checkOutput("underrun", 32'(underrun), 32'(expUr));
    checkOutput("bclk", 32'(bclk), 32'((cyc / CLK_DIV) % 2));
    checkOutput("lrclk", 32'(lrclk), 32'((cyc / (64 * CLK_DIV)) % 2));
    if (cyc == 0) checkOutput("sdata_idle", 32'(sdata), 32'd0);

    if (bclk && !prevBclk) begin
      if (lrclk != prevLr) slotPos = 0;
      else slotPos++;
      prevLr = lrclk;
      if (slotPos >= 1 && slotPos <= 24) begin
        shiftWord = {shiftWord[22:0], sdata};
      end else begin
        checkOutput("pad_bit", 32'(sdata), 32'd0);
      end
      if (slotPos == 24) begin
        if (!lrclk) begin
          gotLeft  = shiftWord;
          haveLeft = 1;
        end else if (haveLeft) begin
          haveLeft = 0;
          checkOutput("frame_queue", 32'(expFrames.size() != 0), 32'd1);
          if (expFrames.size() != 0) begin
            headFrame = expFrames.pop_front();
            checkOutput("left_slot", 32'(gotLeft), 32'(headFrame[47:24]));
            checkOutput("right_slot", 32'(shiftWord), 32'(headFrame[23:0]));
            framesChecked++;
          end
        end
      end
    end
    prevBclk = bclk;

    if (rst) begin
      cyc   = 0;
      pend  = 0;
      expUr = 0;
      expFrames.delete();
      expFrames.push_back('0);
      slotPos  = -1;
      prevLr   = 0;
      prevBclk = 0;
      haveLeft = 0;
    end else begin
      oldReady = !pend;
      cyc++;
      expUr = 0;
      if (cyc % FRAME_CYC == 0) begin
        if (pend && (cyc - acceptEdge >= 4)) begin
          expFrames.push_back({pendL, pendR});
          pend = 0;
        end else begin
          expFrames.push_back('0);
          expUr = 1;
        end
      end
      if (inValid && oldReady) begin
        pend       = 1;
        pendL      = refConv(inLeft);
        pendR      = refConv(inRight);
        acceptEdge = cyc;
        acceptCount++;
      end
    end
  end

  // Offer a pair and wait (bounded) until it is taken; optionally keep
  // in_valid asserted so the next call streams straight after it.
  task automatic applyStimulus(input logic [23:0] l, input logic [23:0] r, input bit hold);
    bit ok;
    inLeft  = l;
    inRight = r;
    inValid = 1'b1;
    sent++;
    ok = 0;
    for (int i = 0; i < 4 * FRAME_CYC; i++) begin
      @(negedge clk);
      if (inReady) begin
        ok = 1;
        break;
      end
    end
    checkOutput("accept_wait", 32'(ok), 32'd1);
    @(posedge clk);
    #1;
    if (!hold) inValid = 1'b0;
  endtask

  task automatic waitPhase(input int phase);
    for (int i = 0; i < 2 * FRAME_CYC; i++) begin
      @(posedge clk);
      if (cyc % FRAME_CYC == phase) break;
    end
    #1;
  endtask

  initial begin
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;

    applyStimulus(24'h3E0000, 24'hBE8000, 0);
    applyStimulus(24'h470000, 24'hC70000, 0);
    applyStimulus(24'h3F0000, 24'hBF0000, 0);
    applyStimulus(24'h000000, 24'h1E0000, 0);
    for (int i = 0; i < 8; i++) applyStimulus(randFloat(), randFloat(), 0);

    // Idle frames after the last delivered pair
    repeat (3 * FRAME_CYC) @(posedge clk);

    // Reset in the middle of a frame with a converted pair pending
    waitPhase(5);
    applyStimulus(randFloat(), randFloat(), 0);
    waitPhase(322);
    rst = 1'b1;
    @(posedge clk);
    #1 rst = 1'b0;
    repeat (FRAME_CYC + 20) @(posedge clk);
    #1;

    // Streaming with in_valid held high
    for (int i = 0; i < 7; i++) begin
      applyStimulus({1'b0, 7'd60, 16'(i * 257)}, {1'b1, 7'd58, 16'(i)}, i != 6);
    end

    repeat (2 * FRAME_CYC + 100) @(posedge clk);
    checkOutput("accept_count", 32'(acceptCount), 32'(sent));
    checkOutput("rx_frames", 32'(framesChecked > sent), 32'd1);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #4000000;
    $display("[TB] FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

endmodule
